// File: rtl/dso_pkg.sv
// -----------------------------------------------------------------------------
// dso_pkg
// Shared definitions for the ADC capture writer:
//   - bit positions and widths of the fields in the 32-bit adc_cfg word
//   - capture FSM state encoding
//   - small helper that tells whether a state is writing samples
// -----------------------------------------------------------------------------
package dso_pkg;

  // adc_cfg field layout
  localparam int CFG_LEVEL_LSB = 0;
  localparam int CFG_LEVEL_W   = 8;
  localparam int CFG_CH        = 8;
  localparam int CFG_EDGE      = 9;
  localparam int CFG_FORCE     = 10;
  localparam int CFG_EN        = 11;
  localparam int CFG_DEC_LSB   = 12;
  localparam int CFG_DEC_W     = 4;
  localparam int CFG_PRE_LSB   = 16;
  localparam int CFG_PRE_W     = 12;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE       = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    DONE      = 3'd4
  } state_e;

  // States in which strobed samples are written to the buffer.
  function automatic logic is_active(input state_e s);
    return (s == PRE) || (s == WAIT_TRIG) || (s == POST);
  endfunction

endpackage

// File: rtl/adc_capture_if.sv
// -----------------------------------------------------------------------------
// adc_capture_if
// Buffer-RAM write port plus capture status of the ADC capture writer.
//   wr_en / wr_addr / wr_data : write port of the dual-port sample buffer
//   ready                     : capture complete
//   busy                      : capture in progress (PRE, WAIT_TRIG, POST)
//   start_addr / trig_addr    : oldest-sample and trigger-sample addresses
// master = capture block (drives everything), slave = RAM / status consumer.
// -----------------------------------------------------------------------------
interface adc_capture_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          ready;
  logic          busy;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] trig_addr;

  modport master (
    output wr_en, wr_addr, wr_data, ready, busy, start_addr, trig_addr
  );

  modport slave (
    input wr_en, wr_addr, wr_data, ready, busy, start_addr, trig_addr
  );
endinterface

// File: rtl/adc_trig_detect.sv
// -----------------------------------------------------------------------------
// adc_trig_detect
// Edge trigger on one 8-bit channel of the ADC sample bus.
//   clk, nrst  : clock, asynchronous active-low reset
//   strobe     : a new sample is taken this cycle
//   sample     : {A[15:8], B[7:0]}
//   level      : trigger threshold
//   ch         : 0 = channel A, 1 = channel B
//   edge_fall  : 0 = rising, 1 = falling
//   clear      : forget the previous sample (new capture / disabled)
//   hit        : this strobed sample crosses the level
// -----------------------------------------------------------------------------
module adc_trig_detect #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          strobe,
  input  logic [DW-1:0] sample,
  input  logic [7:0]    level,
  input  logic          ch,
  input  logic          edge_fall,
  input  logic          clear,
  output logic          hit
);

  logic [7:0] cur_s;
  logic [7:0] prev_q, prev_d;
  logic       vld_q, vld_d;
  logic       cross_s;

  assign cur_s = ch ? sample[7:0] : sample[DW-1 -: 8];

  // Threshold crossing between the previous and the current strobed sample.
  always_comb begin
    cross_s = 1'b0;
    if (edge_fall) begin
      cross_s = (prev_q > level) && (cur_s <= level);
    end else begin
      cross_s = (prev_q < level) && (cur_s >= level);
    end
  end

  // Kept separate from the state update so hit never depends on clear.
  assign hit = strobe & vld_q & cross_s;

  // Previous-sample register and its valid flag.
  always_comb begin
    prev_d = prev_q;
    vld_d  = vld_q;
    if (clear) begin
      vld_d = 1'b0;
    end else if (strobe) begin
      prev_d = cur_s;
      vld_d  = 1'b1;
    end else begin
      vld_d = vld_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prev_q <= 8'h00;
      vld_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      vld_q  <= vld_d;
    end
  end

endmodule

// File: rtl/adc_capture.sv
// -----------------------------------------------------------------------------
// adc_capture
// Writer side of the circular ADC sample buffer. After an MCU arm it records
// P pre-trigger samples, waits for an edge (or forced) trigger, records the
// post-trigger remainder so the buffer holds exactly DEPTH contiguous samples,
// then raises ready and publishes the oldest-sample and trigger addresses.
//   clk       : pll_clk, single clock domain
//   nrst      : asynchronous active-low reset
//   cfg       : adc_cfg word (level, ch, edge, force, enable, dec, P)
//   adc_data  : registered ADC bus {A, B}
//   arm       : MCU capture request, asynchronous to clk
//   cap       : buffer write port and status (adc_capture_if master)
// -----------------------------------------------------------------------------
module adc_capture
  import dso_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [31:0]   cfg,
  input  logic [DW-1:0] adc_data,
  input  logic          arm,
  adc_capture_if.master cap
);

  localparam int DEPTH = 1 << AW;

  // P larger than the buffer can hold is limited to DEPTH-1.
  function automatic logic [AW-1:0] clamp_pre(input logic [CFG_PRE_W-1:0] p);
    if (32'(p) > 32'(DEPTH - 1)) begin
      return AW'(DEPTH - 1);
    end else begin
      return AW'(p);
    end
  endfunction

  state_e                 state_q, state_d;
  logic [2:0]             sync_q;
  logic [AW-1:0]          ptr_q, ptr_d;
  logic [AW-1:0]          cnt_q, cnt_d;
  logic [AW-1:0]          p_q, p_d;
  logic [AW-1:0]          trig_q, trig_d;
  logic [AW-1:0]          start_q, start_d;
  logic [AW-1:0]          wr_addr_q, wr_addr_d;
  logic [DW-1:0]          wr_data_q, wr_data_d;
  logic [CFG_DEC_W-1:0]   div_q, div_d;
  logic                   wr_en_q, wr_en_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;

  logic                   en_s, force_s, arm_rise_s, arm_take_s;
  logic                   active_s, strobe_s, hit_s;
  logic [CFG_DEC_W-1:0]   dec_s;
  logic [AW-1:0]          p_cfg_s, post_len_s;
  logic                   cfg_unused_s;

  assign en_s         = cfg[CFG_EN];
  assign force_s      = cfg[CFG_FORCE];
  assign dec_s        = cfg[CFG_DEC_LSB +: CFG_DEC_W];
  assign p_cfg_s      = clamp_pre(cfg[CFG_PRE_LSB +: CFG_PRE_W]);
  assign cfg_unused_s = ^cfg[31:28];

  // sync_q[1] is the synchronised arm, sync_q[2] its previous value.
  assign arm_rise_s = sync_q[1] & ~sync_q[2];
  assign arm_take_s = en_s & arm_rise_s & ((state_q == IDLE) || (state_q == DONE));

  assign active_s   = is_active(state_q);
  assign strobe_s   = active_s && (div_q == {CFG_DEC_W{1'b0}});
  assign post_len_s = AW'(DEPTH - 1) - p_q;

  adc_trig_detect #(.DW(DW)) u_trig (
    .clk       (clk),
    .nrst      (nrst),
    .strobe    (strobe_s),
    .sample    (adc_data),
    .level     (cfg[CFG_LEVEL_LSB +: CFG_LEVEL_W]),
    .ch        (cfg[CFG_CH]),
    .edge_fall (cfg[CFG_EDGE]),
    .clear     (arm_take_s | ~en_s),
    .hit       (hit_s)
  );

  // Next-state and next-output logic of the capture FSM.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    div_d     = div_q;
    trig_d    = trig_q;
    start_d   = start_q;
    ready_d   = ready_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (!en_s) begin
      // Disable wins over everything; a write that would issue next cycle is dropped.
      state_d = IDLE;
      ready_d = 1'b0;
      div_d   = {CFG_DEC_W{1'b0}};
    end else begin
      if (active_s) begin
        div_d = (div_q >= dec_s) ? {CFG_DEC_W{1'b0}} : div_q + CFG_DEC_W'(1);
      end else begin
        div_d = {CFG_DEC_W{1'b0}};
      end

      if (strobe_s) begin
        wr_en_d   = 1'b1;
        wr_addr_d = ptr_q;
        wr_data_d = adc_data;
        ptr_d     = ptr_q + AW'(1);
      end else begin
        wr_en_d   = 1'b0;
      end

      case (state_q)
        IDLE, DONE: begin
          if (arm_take_s) begin
            // Divider restarts at 0 so the PRE entry cycle is the first strobe.
            state_d = PRE;
            ptr_d   = {AW{1'b0}};
            cnt_d   = {AW{1'b0}};
            div_d   = {CFG_DEC_W{1'b0}};
            p_d     = p_cfg_s;
            ready_d = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        PRE: begin
          // The entry cycle is always a strobe, so P=0 leaves on entry.
          if (strobe_s) begin
            cnt_d = cnt_q + AW'(1);
            if (({1'b0, cnt_q} + (AW + 1)'(1)) >= {1'b0, p_q}) begin
              state_d = WAIT_TRIG;
            end else begin
              state_d = PRE;
            end
          end else begin
            state_d = PRE;
          end
        end
        WAIT_TRIG: begin
          if (strobe_s && (force_s || hit_s)) begin
            trig_d = ptr_q;
            cnt_d  = post_len_s;
            if (post_len_s == {AW{1'b0}}) begin
              state_d = DONE;
              ready_d = 1'b1;
              start_d = ptr_q - p_q;
            end else begin
              state_d = POST;
            end
          end else begin
            state_d = WAIT_TRIG;
          end
        end
        POST: begin
          if (strobe_s) begin
            cnt_d = cnt_q - AW'(1);
            if (cnt_q <= AW'(1)) begin
              state_d = DONE;
              ready_d = 1'b1;
              start_d = trig_q - p_q;
            end else begin
              state_d = POST;
            end
          end else begin
            state_d = POST;
          end
        end
        default: begin
          state_d = IDLE;
          ready_d = 1'b0;
        end
      endcase
    end

    busy_d = is_active(state_d);
  end

  // Arm synchroniser and edge-detect history.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], arm};
    end
  end

  // FSM state, pointers, counters and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      ptr_q     <= {AW{1'b0}};
      cnt_q     <= {AW{1'b0}};
      p_q       <= {AW{1'b0}};
      div_q     <= {CFG_DEC_W{1'b0}};
      trig_q    <= {AW{1'b0}};
      start_q   <= {AW{1'b0}};
      wr_en_q   <= 1'b0;
      wr_addr_q <= {AW{1'b0}};
      wr_data_q <= {DW{1'b0}};
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      div_q     <= div_d;
      trig_q    <= trig_d;
      start_q   <= start_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign cap.wr_en      = wr_en_q;
  assign cap.wr_addr    = wr_addr_q;
  assign cap.wr_data    = wr_data_q;
  assign cap.ready      = ready_q;
  assign cap.busy       = busy_q;
  assign cap.start_addr = start_q;
  assign cap.trig_addr  = trig_q;

endmodule

// File: doc/adc_capture.md
Name: adc_capture

Overview:
Writer side of the ADC sample buffer that the SPI module reads through mem_addr/mem_data. The block sits between the registered {adc_a_d, adc_b_d} input bus and the dual-port ADC buffer RAM. It runs at pll_clk, armed by the MCU. It writes a pre-trigger history and then a post-trigger record into a circular buffer. It then raises a ready flag and publishes the address of the oldest sample so the reader can unroll the buffer.

Parameters:
AW, 12, buffer address width; depth DEPTH = 2^AW
DW, 16, sample width; {A[15:8], B[7:0]}

Ports:
clk  in  1  sample/system clock (pll_clk); single clock domain
nrst  in  1  asynchronous active-low reset
cfg  in  32  adc_cfg word from SPI config register
adc_data  in  DW  registered ADC bus, A in [15:8], B in [7:0]
arm  in  1  MCU capture request (trigger_mcu); asynchronous to clk
wr_en  out  1  buffer RAM write enable
wr_addr  out  AW  buffer RAM write address
wr_data  out  DW  buffer RAM write data
ready  out  1  capture complete (drives ready_mcu)
busy  out  1  high in PRE, WAIT_TRIG and POST
start_addr  out  AW  address of oldest sample; valid while ready=1
trig_addr  out  AW  address of the trigger sample; valid while ready=1

Behaviour:
- Reset: every output is 0; state IDLE; pointer, counters and synchroniser are 0.
- cfg fields:
  - [7:0] level
  - [8] channel (0=A, 1=B)
  - [9] edge (0 rising, 1 falling)
  - [10] force (trigger on first WAIT_TRIG sample)
  - [11] enable
  - [15:12] dec
  - [27:16] P = pretrigger count
  - [31:28] reserved, ignored
- P clamp: if P > DEPTH-1, use DEPTH-1.
- arm path: 2-flop synchroniser, then rising-edge detect. The IDLE->PRE transition occurs 3 clk after the arm rising edge.
- arm is honoured only in IDLE or DONE. It is ignored in PRE, WAIT_TRIG and POST.
- Sample strobe: a divider counts 0..dec and strobes at 0. The divider restarts at 0 on entry to PRE, so the first strobe is the PRE entry cycle. Sample rate is clk/(dec+1).
- Write timing: on a strobe in PRE, WAIT_TRIG or POST, the next cycle has wr_en=1, wr_addr=ptr, wr_data=adc_data sampled on the strobe cycle. The pointer then advances modulo DEPTH. Otherwise wr_en=0.
- Trigger detect, applied to the selected channel byte, comparing the current sample cur with the previous strobed sample prev:
  - rising: prev < level and cur >= level
  - falling: prev > level and cur <= level
  - prev is invalid on the first sample after arm; no trigger is possible on that sample.
  - prev updates on every strobe, including in PRE.
- States:
  - IDLE: wr_en=0. On a valid arm: ptr<=0, cnt<=0, ready<=0, go to PRE.
  - PRE: write P samples, then go to WAIT_TRIG. If P=0, go to WAIT_TRIG on the entry cycle. Triggers are ignored in PRE.
  - WAIT_TRIG: write every strobed sample; the pointer wraps freely. On a trigger sample (or the first sample if force=1): that sample is written, trig_addr<=its address, post counter<=DEPTH-1-P, go to POST. If DEPTH-1-P = 0, go directly to DONE.
  - POST: write one sample per strobe and decrement the counter; at 0, go to DONE.
  - DONE: wr_en=0, ready=1, start_addr=(trig_addr-P) mod DEPTH. Holds until a valid arm (restart) or enable=0.
- enable=0 in any state: IDLE on the next clk; ready, busy and wr_en are 0. Any in-flight write is dropped.
- Buffer contents: after DONE, exactly DEPTH contiguous samples end at trig_addr+DEPTH-1-P. The oldest sample sits at start_addr.
- Simultaneous events: enable=0 wins over arm and trigger. A trigger coinciding with the PRE->WAIT_TRIG transition is ignored.
- nrst asserted mid-capture: immediate return to reset values. No partial ready.

Decomposition:
- Package dso_pkg holds:
  - cfg field bit positions/widths: CFG_LEVEL, CFG_CH, CFG_EDGE, CFG_FORCE, CFG_EN, CFG_DEC, CFG_PRE.
  - the state encoding: IDLE, PRE, WAIT_TRIG, POST, DONE.
- One sub-module, adc_trig_detect, owns the channel mux, prev register, prev-valid flag and edge comparison. Its inputs are strobe, sample, level, ch, edge and clear. Its output is a 1-bit hit.

Test Plan:
1. Rising trigger on a ramp:
   - Setup: A = free 8-bit ramp starting 0x00 at the first PRE strobe; cfg level=0x80, ch=A, rising, dec=0, P=100, enable=1.
   - Required: PRE writes addr 0..99 (A=0x00..0x63); trig_addr=128; 3995 post writes, last at addr 27; ready=1; start_addr=28.
2. Falling trigger on channel B:
   - Setup: B ramps down from 0xFF; level=0x40, falling, P=0.
   - Required: trig_addr=191 (B=0x40); start_addr=191; 4095 post writes.
3. Decimation:
   - Setup: dec=3, force=1, P=10.
   - Required: wr_en pulses exactly every 4 clk; trig_addr=10; start_addr=0; total writes 4096.
4. Abort:
   - Setup: clear enable mid-POST.
   - Required: next clk IDLE, wr_en=0, busy=0, ready=0. A later arm restarts with ptr=0.
5. Arm while busy:
   - Setup: arm pulse during WAIT_TRIG.
   - Required: ignored; capture completes normally. An arm in DONE drops ready 3 clk later and restarts.
6. Reset mid-capture:
   - Setup: nrst low during WAIT_TRIG.
   - Required: all outputs 0 asynchronously; no writes until the next arm.
